// File: rtl/spi_hash_rd.sv
// spi_hash_rd: SPI mode-0 slave that walks the hash word-select mux from
// word 0 upward and streams each 32-bit word MSB-first on MISO. All SPI pins
// are synchronised into clk; the SPI edges become single-clk flags.
module spi_hash_rd #(
  parameter int WORDS       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [3:0]  rd_addr,
  input  logic [31:0] rd_d,
  output logic        rd_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam logic [3:0] ADDR_SAT  = 4'(WORDS);
  localparam logic [3:0] ADDR_LAST = 4'(WORDS - 1);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sck_s, cs_s;
  logic                   sck_rise, sck_fall, cs_fall;

  state_t      state_q, state_d;
  logic [31:0] shreg_q, shreg_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  rd_addr_q, rd_addr_d;
  logic        oe_q, oe_d;
  logic        rd_done_q, rd_done_d;

  // Synchroniser shift chains plus one history flop per pin for edge detection
  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    sck_prev_d = sck_sync_q[SYNC_STAGES-1];
    cs_prev_d  = cs_sync_q[SYNC_STAGES-1];
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  // Next-state and datapath: CS high always wins over any same-clk SCK edge
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    rd_addr_d = rd_addr_q;
    oe_d      = oe_q;
    rd_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        oe_d      = 1'b0;
        rd_addr_d = 4'd0;
        bit_cnt_d = 5'd0;
        if (cs_fall) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cs_s) begin
          state_d   = ST_IDLE;
          oe_d      = 1'b0;
          rd_addr_d = 4'd0;
          bit_cnt_d = 5'd0;
        end else begin
          shreg_d = rd_d;
          oe_d    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_s) begin
          state_d   = ST_IDLE;
          oe_d      = 1'b0;
          rd_addr_d = 4'd0;
          bit_cnt_d = 5'd0;
        end else if (sck_rise) begin
          bit_cnt_d = 5'(bit_cnt_q + 5'd1);
          if (bit_cnt_q == 5'd31) begin
            // Address saturates at WORDS; the mux returns zero there
            if (rd_addr_q < ADDR_SAT) begin
              rd_addr_d = 4'(rd_addr_q + 4'd1);
            end else begin
              rd_addr_d = rd_addr_q;
            end
            if (rd_addr_q == ADDR_LAST) begin
              rd_done_d = 1'b1;
            end else begin
              rd_done_d = 1'b0;
            end
          end else begin
            rd_addr_d = rd_addr_q;
          end
        end else if (sck_fall) begin
          // bit_cnt wrapped to 0 means a full word was taken: fetch the next one
          if (bit_cnt_q == 5'd0) begin
            shreg_d = rd_d;
          end else begin
            shreg_d = {shreg_q[30:0], 1'b0};
          end
        end else begin
          shreg_d = shreg_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        oe_d      = 1'b0;
        rd_addr_d = 4'd0;
        bit_cnt_d = 5'd0;
      end
    endcase
  end

  // State, datapath and synchroniser registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q <= '0;
      cs_sync_q  <= '1;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      shreg_q    <= 32'd0;
      bit_cnt_q  <= 5'd0;
      rd_addr_q  <= 4'd0;
      oe_q       <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      cs_sync_q  <= cs_sync_d;
      sck_prev_q <= sck_prev_d;
      cs_prev_q  <= cs_prev_d;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      rd_addr_q  <= rd_addr_d;
      oe_q       <= oe_d;
      rd_done_q  <= rd_done_d;
    end
  end

  assign spi_miso    = (state_q == ST_SHIFT) & shreg_q[31];
  assign spi_miso_oe = oe_q;
  assign rd_addr     = rd_addr_q;
  assign rd_done     = rd_done_q;

endmodule

// File: tb/tb_spi_hash_rd.sv
// Directed bench for spi_hash_rd: a behavioural hash mux feeds rd_d and a
// host model clocks SCK at 1/16 of clk, sampling MISO just before each rise.
module tb_spi_hash_rd;

  logic        clk;
  logic        rst_n;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [3:0]  rd_addr;
  logic [31:0] rd_d;
  logic        rd_done;

  logic [31:0] mem [0:15];
  int          n_checks;
  int          n_errors;
  int          done_cnt;

  spi_hash_rd #(.WORDS(12), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .rd_addr     (rd_addr),
    .rd_d        (rd_d),
    .rd_done     (rd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hash word-select mux model: zero beyond the last valid word
  always_comb begin
    if (rd_addr < 4'd12) rd_d = mem[rd_addr];
    else                 rd_d = 32'h0;
  end

  // Count rd_done pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (rd_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_bit(output logic b);
    b = spi_miso;
    spi_sck = 1'b1;
    wait_clk(8);
    spi_sck = 1'b0;
    wait_clk(8);
  endtask

  task automatic read_word(output logic [31:0] w);
    logic b;
    w = 32'h0;
    for (int i = 0; i < 32; i++) begin
      read_bit(b);
      w = {w[30:0], b};
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clk(10);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    wait_clk(10);
  endtask

  logic [31:0] w;
  logic        b;

  initial begin
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst_n    = 1'b0;
    spi_sck  = 1'b0;
    spi_cs_n = 1'b0;

    // 1: reset held with SCK toggling and CS low
    for (int i = 0; i < 6; i++) begin
      spi_sck = ~spi_sck;
      wait_clk(4);
      check_eq("rst_miso", {31'h0, spi_miso}, 32'h0);
      check_eq("rst_oe", {31'h0, spi_miso_oe}, 32'h0);
      check_eq("rst_addr", {28'h0, rd_addr}, 32'h0);
    end
    check_eq("rst_done", done_cnt, 32'd0);
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(5);

    // 2: single word
    mem[0] = 32'hA5C3_0F81;
    cs_low();
    check_eq("w_oe", {31'h0, spi_miso_oe}, 32'h1);
    w = 32'h0;
    for (int i = 0; i < 31; i++) begin
      read_bit(b);
      w = {w[30:0], b};
    end
    check_eq("w_addr31", {28'h0, rd_addr}, 32'h0);
    read_bit(b);
    w = {w[30:0], b};
    check_eq("w_data", w, 32'hA5C3_0F81);
    check_eq("w_addr32", {28'h0, rd_addr}, 32'h1);
    cs_high();
    check_eq("w_oe_off", {31'h0, spi_miso_oe}, 32'h0);
    check_eq("w_addr_idle", {28'h0, rd_addr}, 32'h0);

    // 3: full read of 12 words
    for (int i = 0; i < 12; i++) mem[i] = 32'(i + 1);
    done_cnt = 0;
    cs_low();
    for (int i = 0; i < 12; i++) begin
      read_word(w);
      check_eq($sformatf("full_w%0d", i), w, 32'(i + 1));
      if (i == 10) check_eq("full_nodone", done_cnt, 32'd0);
    end
    check_eq("full_done", done_cnt, 32'd1);
    check_eq("full_addr", {28'h0, rd_addr}, 32'd12);

    // 4: overrun past the last word
    for (int i = 0; i < 2; i++) begin
      read_word(w);
      check_eq($sformatf("ovr_w%0d", i), w, 32'h0);
    end
    check_eq("ovr_addr", {28'h0, rd_addr}, 32'd12);
    check_eq("ovr_done", done_cnt, 32'd1);
    cs_high();

    // 5: abort after 20 bits of word 3, then restart
    done_cnt = 0;
    cs_low();
    for (int i = 0; i < 3; i++) read_word(w);
    for (int i = 0; i < 20; i++) read_bit(b);
    check_eq("abt_addr_mid", {28'h0, rd_addr}, 32'd3);
    cs_high();
    cs_low();
    check_eq("abt_addr", {28'h0, rd_addr}, 32'd0);
    read_word(w);
    check_eq("abt_w0", w, 32'h1);
    check_eq("abt_done", done_cnt, 32'd0);
    cs_high();

    // 6: reset pulse during word 5
    cs_low();
    for (int i = 0; i < 5; i++) read_word(w);
    for (int i = 0; i < 10; i++) read_bit(b);
    check_eq("mrst_oe_pre", {31'h0, spi_miso_oe}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_miso", {31'h0, spi_miso}, 32'h0);
    check_eq("mrst_oe", {31'h0, spi_miso_oe}, 32'h0);
    check_eq("mrst_addr", {28'h0, rd_addr}, 32'h0);
    check_eq("mrst_done", {31'h0, rd_done}, 32'h0);
    spi_cs_n = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    cs_low();
    read_word(w);
    check_eq("mrst_w0", w, 32'h1);
    read_word(w);
    check_eq("mrst_w1", w, 32'h2);
    cs_high();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
